// File: rtl/mem_bus_ctrl_if.sv
// Mem-stage request side and shared-bus side of the memory bus controller.
// master: controller view; slave: mem stage plus bus fabric view.
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_ce_in;
    logic              req_we_in;
    logic [ADDR_W-1:0] req_addr_in;
    logic [DATA_W-1:0] req_wdata_in;
    logic [DATA_W-1:0] rdata_out;
    logic              stall_out;
    logic              bus_req_out;
    logic              bus_we_out;
    logic [ADDR_W-1:0] bus_addr_out;
    logic [DATA_W-1:0] bus_wdata_out;
    logic [DATA_W-1:0] bus_rdata_in;
    logic              bus_ack_in;
    logic              bus_err_out;

    modport master (
        input  req_ce_in, req_we_in, req_addr_in, req_wdata_in,
        input  bus_rdata_in, bus_ack_in,
        output rdata_out, stall_out,
        output bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_err_out
    );

    modport slave (
        output req_ce_in, req_we_in, req_addr_in, req_wdata_in,
        output bus_rdata_in, bus_ack_in,
        input  rdata_out, stall_out,
        input  bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_err_out
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Converts mem's single-cycle RAM access into a req/ack bus transaction (sub-word stores as read-modify-write).
// Latency: load 3 / store 4 cycles plus bus wait cycles; stalls the pipeline until DONE, aborts dead slaves.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk_in,
    input  logic           reset_in,
    mem_bus_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam bit         TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              req_q, req_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              err_q, err_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic              timeout_hit;
    logic              unused_addr_lsb;

    // Byte/half lane selection is mem's job; only the word address goes out.
    assign unused_addr_lsb = ^bus.req_addr_in[1:0];
    assign timeout_hit     = TO_EN && (cnt_q == TO_LIMIT);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            rdata_q <= rdata_nxt;
            req_q   <= req_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        rdata_nxt = rdata_q;
        req_nxt   = req_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_ce_in) begin
                    addr_nxt  = {bus.req_addr_in[ADDR_W-1:2], 2'b00};
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = RD;
                end
            end
            RD: begin
                if (bus.bus_ack_in) begin
                    rdata_nxt = bus.bus_rdata_in;
                    cnt_nxt   = '0;
                    if (bus.req_we_in) begin
                        we_nxt    = 1'b1;
                        state_nxt = WR;
                    end else begin
                        req_nxt   = 1'b0;
                        state_nxt = DONE;
                    end
                end else if (timeout_hit) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                end
            end
            WR: begin
                // An ack on the limit cycle still counts as a completed write.
                if (bus.bus_ack_in) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rdata_out     = rdata_q;
    assign bus.bus_req_out   = req_q;
    assign bus.bus_we_out    = we_q;
    assign bus.bus_addr_out  = addr_q;
    assign bus.bus_err_out   = err_q;
    // mem merges against the registered read word, so its store word is live all through WR.
    assign bus.bus_wdata_out = (state_q == WR) ? bus.req_wdata_in : '0;
    assign bus.stall_out     = !reset_in && bus.req_ce_in && (state_q != DONE);
endmodule
